// File: rtl/queue_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : queue_reader_pkg
// Brief    : Shared types and constants for the queue_reader block.
//            The optional stall counter is enabled by QUEUE_READER_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package queue_reader_pkg;

    // Two-state controller: gather symbols, then present the packed word
    typedef enum logic [0:0] {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    localparam int unsigned c_def_width = 2;
    localparam int unsigned c_def_pack  = 4;
    localparam int unsigned c_stall_w   = 16;

endpackage
`default_nettype wire

// File: rtl/queue_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : queue_reader_if
// Brief    : Bundles the queue-side pop handshake, the flush pulse and the
//            valid/ready word output of queue_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface queue_reader_if
    import queue_reader_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int PACK  = c_def_pack
);
    localparam int CW = $clog2(PACK + 1);

    logic                  q_empty;
    logic [WIDTH-1:0]      q_data;
    logic                  q_pop;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [WIDTH*PACK-1:0] m_data;
    logic [CW-1:0]         m_count;

    // Reader side
    modport master (
        input  q_empty, q_data, flush, m_ready,
        output q_pop, m_valid, m_data, m_count
    );

    // Environment side (queue + downstream consumer)
    modport slave (
        output q_empty, q_data, flush, m_ready,
        input  q_pop, m_valid, m_data, m_count
    );

endinterface
`default_nettype wire

// File: rtl/queue_reader_ctl.sv
`default_nettype none
// ============================================================================
// Module   : queue_reader_ctl
// Brief    : FILL/OUT controller for queue_reader. Generates q_pop and
//            m_valid, tracks the in-flight pop (pend) and a pending flush.
// Revision : 1.0 - initial release
// ============================================================================
module queue_reader_ctl
    import queue_reader_pkg::*;
#(
    parameter int PACK = c_def_pack,
    parameter int CW   = $clog2(PACK + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_q_empty,
    input  logic          i_flush,
    input  logic          i_m_ready,
    input  logic [CW-1:0] i_cnt,
    output logic          o_q_pop,
    output logic          o_m_valid,
    output logic          o_capture,
    output logic          o_handoff
);

    localparam logic [CW:0]   c_pack_ext  = PACK[CW:0];
    localparam logic [CW-1:0] c_last_slot = CW'(PACK - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_pend;
    logic         w_pend_nxt;
    logic         r_flush_req;
    logic         w_flush_req_nxt;
    logic [CW:0]  w_occupancy;
    logic         w_q_pop;
    logic         w_capture;
    logic         w_handoff;
    logic         w_last_slot;
    logic         w_flush_go;
    logic         w_flush_drop;

    // State, in-flight pop flag and flush request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FILL;
            r_pend      <= 1'b0;
            r_flush_req <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_flush_req <= w_flush_req_nxt;
        end
    end

    // Next-state, pop issue and capture/hand-off strobes
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_nxt      = 1'b0;
        w_flush_req_nxt = r_flush_req;
        w_q_pop         = 1'b0;
        w_capture       = 1'b0;
        w_handoff       = 1'b0;
        // Slots already filled plus the one in flight; one extra bit so PACK fits
        w_occupancy     = {1'b0, i_cnt} + {{CW{1'b0}}, r_pend};
        w_last_slot     = 1'b0;
        w_flush_go      = 1'b0;
        w_flush_drop    = 1'b0;

        case (r_state)
            FILL: begin
                // rst gates the pop so nothing leaves the queue while held in reset
                w_q_pop      = rst & ~i_q_empty & ~r_flush_req & (w_occupancy < c_pack_ext);
                w_pend_nxt   = w_q_pop;
                w_capture    = r_pend;
                w_last_slot  = r_pend & (i_cnt == c_last_slot);
                // A flush waits for the in-flight symbol to land before emitting
                w_flush_go   = r_flush_req & ~r_pend & (i_cnt != '0);
                w_flush_drop = r_flush_req & ~r_pend & (i_cnt == '0);
                if (w_last_slot || w_flush_go) begin
                    w_state_nxt = OUT;
                end
                w_flush_req_nxt = (r_flush_req & ~w_flush_drop) | i_flush;
            end
            OUT: begin
                // Flush pulses are ignored here; the word is already being offered
                if (i_m_ready) begin
                    w_handoff       = 1'b1;
                    w_state_nxt     = FILL;
                    w_flush_req_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    assign o_q_pop   = w_q_pop;
    assign o_m_valid = (r_state == OUT);
    assign o_capture = w_capture;
    assign o_handoff = w_handoff;

endmodule
`default_nettype wire

// File: rtl/queue_reader.sv
`default_nettype none
// ============================================================================
// Module   : queue_reader
// Brief    : Pops WIDTH-bit symbols from a Queue, packs PACK of them into one
//            word (symbol 0 in the LSBs) and offers it on valid/ready. A flush
//            pulse emits the current partial word with unfilled slots at 0.
//            Define QUEUE_READER_STALL_CNT_EN to add the stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module queue_reader
    import queue_reader_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int PACK  = c_def_pack
) (
    input  logic                 clk,
    input  logic                 rst,
    queue_reader_if.master       bus
`ifdef QUEUE_READER_STALL_CNT_EN
    ,
    output logic [c_stall_w-1:0] stall_cnt
`endif
);

    localparam int CW = $clog2(PACK + 1);

    logic [CW-1:0]         r_cnt;
    logic [WIDTH*PACK-1:0] r_word;
    logic                  w_q_pop;
    logic                  w_m_valid;
    logic                  w_capture;
    logic                  w_handoff;

    queue_reader_ctl #(
        .PACK (PACK),
        .CW   (CW)
    ) u_ctl (
        .clk       (clk),
        .rst       (rst),
        .i_q_empty (bus.q_empty),
        .i_flush   (bus.flush),
        .i_m_ready (bus.m_ready),
        .i_cnt     (r_cnt),
        .o_q_pop   (w_q_pop),
        .o_m_valid (w_m_valid),
        .o_capture (w_capture),
        .o_handoff (w_handoff)
    );

    // Word assembly: write the captured symbol into slot r_cnt, clear on hand-off
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (w_handoff) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < PACK; i++) begin
                if (r_cnt == CW'(i)) begin
                    r_word[i*WIDTH +: WIDTH] <= bus.q_data;
                end
            end
            r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef QUEUE_READER_STALL_CNT_EN
    logic [c_stall_w-1:0] r_stall_cnt;

    // Saturating count of cycles the word is offered but not accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !bus.m_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bus.q_pop   = w_q_pop;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = r_word;
    assign bus.m_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_queue_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_reader
// Brief    : Self-checking bench for queue_reader (WIDTH=2, PACK=4). A queue
//            model feeds the design; every emitted word is compared with the
//            symbols popped since the previous word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_reader;
    import queue_reader_pkg::*;

    localparam int WIDTH = 2;
    localparam int PACK  = 4;
    localparam int CW    = $clog2(PACK + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    queue_reader_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();

`ifdef QUEUE_READER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    queue_reader #(
        .WIDTH (WIDTH),
        .PACK  (PACK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef QUEUE_READER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Environment / reference state
    logic [WIDTH-1:0]      fifo[$];
    logic [WIDTH-1:0]      popped[$];
    logic                  flush_seen = 1'b0;
    logic                  prev_stall = 1'b0;
    logic [WIDTH*PACK-1:0] held_data  = '0;
    logic [CW-1:0]         held_count = '0;
    int                    stall_exp  = 0;
    int                    pop_cnt    = 0;
    int                    words      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] s);
        fifo.push_back(s);
        bus.q_empty = 1'b0;
    endtask

    // One clock cycle: sample just after the input change, advance, model the queue
    task automatic tick();
        logic                  pop_now;
        logic                  handoff;
        logic [WIDTH*PACK-1:0] exp_word;
        #1;
        pop_now = bus.q_pop;
        handoff = bus.m_valid & bus.m_ready;
        if (pop_now) begin
            pop_cnt++;
            chk("pop_not_empty", {31'b0, bus.q_empty}, 0);
        end
        if (bus.m_valid) chk("no_pop_in_out", {31'b0, pop_now}, 0);
        if (prev_stall) begin
            chk("hold_data", bus.m_data, held_data);
            chk("hold_count", bus.m_count, held_count);
        end
        prev_stall = bus.m_valid & ~bus.m_ready;
        held_data  = bus.m_data;
        held_count = bus.m_count;
        if (bus.m_valid && !bus.m_ready) stall_exp++;
        if (bus.flush && !bus.m_valid) flush_seen = 1'b1;
        if (handoff) begin
            exp_word = '0;
            for (int i = 0; i < popped.size() && i < PACK; i++)
                exp_word[i*WIDTH +: WIDTH] = popped[i];
            chk("word_nonempty", {31'b0, popped.size() > 0}, 1);
            chk("word_data", bus.m_data, exp_word);
            chk("word_count", bus.m_count, popped.size());
            if (!flush_seen) chk("word_full", bus.m_count, PACK);
            words++;
        end
        @(posedge clk);
        #1;
        if (handoff) begin
            popped.delete();
            flush_seen = 1'b0;
        end
        if (pop_now && fifo.size() > 0) begin
            bus.q_data = fifo.pop_front();
            popped.push_back(bus.q_data);
            chk("pops_per_word", {31'b0, popped.size() <= PACK}, 1);
        end
        bus.q_empty = (fifo.size() == 0);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        #1;
        while (!bus.m_valid && n < 40) begin
            tick();
            n++;
            #1;
        end
        chk(tag, {31'b0, bus.m_valid}, 1);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int                    n;
        logic [WIDTH-1:0]      a, b, s, s3;
        logic [WIDTH*PACK-1:0] exp8;

        rst         = 1'b1;
        bus.q_empty = 1'b1;
        bus.q_data  = '0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        #2 rst = 1'b0;

        // Reset with a non-empty queue
        push(2'b01); push(2'b10); push(2'b11); push(2'b00);
        @(negedge clk);
        tick();
        tick();
        #1;
        chk("rst_q_pop", {31'b0, bus.q_pop}, 0);
        chk("rst_m_valid", {31'b0, bus.m_valid}, 0);
        chk("rst_m_data", bus.m_data, 8'h00);
        chk("rst_m_count", bus.m_count, 0);
        rst = 1'b1;
        #1;
        chk("rel_q_pop", {31'b0, bus.q_pop}, 1);

        // Full word at full throughput
        pop_cnt = 0;
        wait_valid("full_valid", n);
        chk("full_latency", n, 5);
        chk("full_pops", pop_cnt, 4);
        chk("full_data", bus.m_data, 8'h39);
        chk("full_count", bus.m_count, 4);
        tick();
        #1;
        chk("full_done", {31'b0, bus.m_valid}, 0);

        // Backpressure for 5 cycles
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 3)));
        wait_valid("bp_valid0", n);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("bp_valid", {31'b0, bus.m_valid}, 1);
        end
`ifdef QUEUE_READER_STALL_CNT_EN
        chk("bp_stall_cnt", stall_cnt, 5);
`endif
        bus.m_ready = 1'b1;
        tick();
        #1;
        chk("bp_done", {31'b0, bus.m_valid}, 0);

        // Starvation gap between symbols
        a = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
        push(a); push(b);
        for (int i = 0; i < 12; i++) begin
            tick();
            #1;
            chk("starve_no_valid", {31'b0, bus.m_valid}, 0);
        end
        push(2'b11); push(2'b11);
        wait_valid("starve_valid", n);
        exp8 = {2'b11, 2'b11, b, a};
        chk("starve_data", bus.m_data, exp8);
        tick();

        // Flush of a 3-symbol partial word
        push(2'b01); push(2'b01); push(2'b10);
        for (int i = 0; i < 6; i++) tick();
        pulse_flush();
        wait_valid("flush3_valid", n);
        chk("flush3_data", bus.m_data, 8'h25);
        chk("flush3_count", bus.m_count, 3);
        tick();

        // Flush with nothing collected
        for (int i = 0; i < 3; i++) tick();
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("flush0_no_valid", {31'b0, bus.m_valid}, 0);
        end
        for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 3)));
        #1;
        chk("flush0_pop_resumes", {31'b0, bus.q_pop}, 1);
        wait_valid("flush0_valid", n);
        chk("flush0_count", bus.m_count, 4);
        tick();

        // Flush while the only symbol is in flight
        s = 2'($urandom_range(0, 3));
        push(s);
        #1;
        chk("inflight_pop", {31'b0, bus.q_pop}, 1);
        tick();
        pulse_flush();
        wait_valid("inflight_valid", n);
        exp8 = {6'b0, s};
        chk("inflight_count", bus.m_count, 1);
        chk("inflight_data", bus.m_data, exp8);
        tick();

        // Flush coincident with the last-slot capture
        for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 3)));
        for (int i = 0; i < 4; i++) tick();
        pulse_flush();
        #1;
        chk("lastflush_valid", {31'b0, bus.m_valid}, 1);
        chk("lastflush_count", bus.m_count, 4);
        tick();
        for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 3)));
        wait_valid("postflush_valid", n);
        chk("postflush_count", bus.m_count, 4);
        tick();

        // Reset in the middle of a fill
        for (int i = 0; i < 4; i++) push(2'($urandom_range(0, 3)));
        s3 = fifo[3];
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        #1;
        chk("midrst_count", bus.m_count, 0);
        chk("midrst_data", bus.m_data, 8'h00);
        chk("midrst_q_pop", {31'b0, bus.q_pop}, 0);
        chk("midrst_valid", {31'b0, bus.m_valid}, 0);
        popped.delete();
        flush_seen = 1'b0;
        prev_stall = 1'b0;
        stall_exp  = 0;
        tick();
`ifdef QUEUE_READER_STALL_CNT_EN
        chk("midrst_stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b1;
        for (int i = 0; i < 3; i++) push(2'($urandom_range(0, 3)));
        wait_valid("midrst_valid", n);
        chk("midrst_word_count", bus.m_count, 4);
        chk("midrst_slot0", {30'b0, bus.m_data[1:0]}, {30'b0, s3});
        tick();

        // Randomized traffic against the reference
        for (int c = 0; c < 400; c++) begin
            if (fifo.size() < 8 && $urandom_range(0, 3) != 0) push(2'($urandom_range(0, 3)));
            bus.m_ready = ($urandom_range(0, 2) != 0);
            bus.flush   = ($urandom_range(0, 19) == 0);
            tick();
            bus.flush = 1'b0;
        end
        bus.m_ready = 1'b1;
        pulse_flush();
        for (int i = 0; i < 20; i++) tick();
        chk("random_words_seen", {31'b0, words > 20}, 1);
`ifdef QUEUE_READER_STALL_CNT_EN
        chk("random_stall_cnt", stall_cnt, stall_exp);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/queue_reader.md
Name: queue_reader

Overview:
- Consumer-side companion to the team's Queue.
- Drives the queue's pop input, captures popped WIDTH-bit symbols and packs PACK of them into one wide word.
- Presents the word on a valid/ready output port.
- Sits between a Queue instance and downstream word-oriented logic; supports an early flush that emits a partial word.

Parameters:
- WIDTH, 2, bits per queue symbol; must equal the attached Queue's WIDTH.
- PACK, 4, symbols per output word; must be ≥ 2.
- CW, $clog2(PACK+1), derived localparam; width of the slot counter and of m_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- q_empty  input  1  empty flag from the Queue.
- q_data  input  WIDTH  Queue data_out; valid the cycle after a pop.
- q_pop  output  1  pop request to the Queue.
- flush  input  1  single-cycle pulse; emit the current partial word.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- m_data  output  WIDTH*PACK  packed word; symbol 0 in the LSBs.
- m_count  output  CW  number of valid symbols in m_data (1..PACK).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FILL; cnt=0; pend=0; flush_req=0; word=0.
  - Outputs: m_valid=0, m_data=0, m_count=0.
  - q_pop is gated to 0 while rst=0.
- State FILL:
  - q_pop = ~q_empty & ~flush_req & (cnt+pend < PACK).
  - pend <= q_pop.
  - If pend=1: word[cnt*WIDTH +: WIDTH] <= q_data; cnt <= cnt+1.
  - Latency: a symbol popped in cycle N is captured at the end of cycle N+1.
  - Throughput: one symbol per cycle when the queue is non-empty.
- FILL -> OUT, on either condition:
  - pend=1 and cnt=PACK-1 (last slot captured this cycle); or
  - flush_req=1, pend=0 and cnt>0.
- State OUT:
  - m_valid=1; m_data=word; m_count=cnt.
  - q_pop=0 throughout.
  - m_data and m_count are held stable until m_ready=1.
- OUT -> FILL: on m_valid & m_ready. Same edge: cnt<=0, word<=0, flush_req<=0.
- Flush handling:
  - A flush pulse in FILL sets flush_req.
  - No new pops are issued while flush_req=1; any in-flight pend symbol is still captured before OUT.
  - If flush_req=1 with cnt=0 and pend=0, flush_req is cleared and no word is emitted.
  - A flush pulse in OUT is ignored.
- Unfilled slots of a partial word read as 0.
- Boundary conditions:
  - q_empty=1: no pop; FILL waits indefinitely; no timeout.
  - pop issued on the same cycle the queue becomes empty is never issued, because q_pop is qualified by the current q_empty.
  - flush and the last-slot capture in the same cycle: full word, m_count=PACK; flush_req cleared on the hand-off.
  - Reset mid-operation: a symbol already popped but not yet captured is lost. This is acceptable; upstream re-initialises.
  - cnt never exceeds PACK; cnt+pend is computed in CW+1 bits.

Optional Feature:
- Macro QUEUE_READER_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - Increments each cycle with m_valid=1 and m_ready=0; saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package queue_reader_pkg:
  - state typedef: FILL=1'b0, OUT=1'b1.
  - Default WIDTH and PACK constants.
  - Stall counter width constant (16).
- Sub-module queue_reader_ctl:
  - Contains the FSM, the q_pop/m_valid generation, the pend and flush_req flags.
  - Top-level queue_reader holds the word register, slot counter and optional stall counter.

Test Plan (WIDTH=2, PACK=4):
1. Reset: hold rst=0 with q_empty=0 -> q_pop=0, m_valid=0, m_data=8'h00, m_count=0; release -> q_pop=1 next cycle.
2. Full word: queue holds 01,10,11,00 with m_ready=1 -> q_pop high 4 consecutive cycles; m_valid for one cycle after the 4th capture with m_data=8'h39, m_count=4.
3. Backpressure: complete a word with m_ready=0 for 5 cycles -> m_valid=1, m_data stable, q_pop=0 throughout; with the macro defined, stall_cnt=5; word is accepted when m_ready=1.
4. Starvation: push 2 symbols, keep the queue empty 10 cycles, then push 11,11 -> no m_valid during the gap; final m_data=8'hF0 | first two symbols.
5. Flush:
   - After 01,01,10, pulse flush -> m_data=8'h25, m_count=3.
   - flush with cnt=0 -> no m_valid, no pop blocked afterwards.
   - flush coincident with a pend capture -> in-flight symbol included.
6. Reset mid-fill: at cnt=2 assert rst=0 -> all state cleared; the next word starts at slot 0 with m_count=4 on completion.
